// File: rtl/pmbist_mem_collar.sv
// ---------------------------------------------------------------------------
// pmbist_mem_collar
//
// Collar that sits between a single-port memory and both its functional user
// and a programmable MBIST controller. While a test is active it steers the
// memory port to the BIST address/data and compares read data against the
// expected background. It accumulates a sticky fail flag, a saturating fail
// count and the first failing address/mask. When the test ends, those results
// are captured into a scan-out result register.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   mbist_run           : controller test-active level
//   i_addr_x/i_addr_y   : BIST column / row address
//   i_data              : BIST write data, also the expected read data
//   i_cs/i_we/i_re      : BIST chip select, write enable, read enable
//   i_comp_en           : compare the read issued this cycle
//   fn_addr/fn_wdata    : functional address / write data
//   fn_we/fn_re         : functional write / read enable
//   mem_rdata           : memory read data, valid one cycle after mem_re
//   mem_addr/mem_wdata  : memory address / write data
//   mem_we/mem_re       : memory write / read enable
//   o_fail_flag         : sticky fail indication to the controller
//   shift_result, si, so: result register shift enable, scan in, scan out
// ---------------------------------------------------------------------------
module pmbist_mem_collar #(
    parameter int ADDR_X  = 2,
    parameter int ADDR_Y  = 2,
    parameter int BG_DATA = 2,
    parameter int CNT_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mbist_run,
    input  logic [ADDR_X-1:0]          i_addr_x,
    input  logic [ADDR_Y-1:0]          i_addr_y,
    input  logic [BG_DATA-1:0]         i_data,
    input  logic                       i_cs,
    input  logic                       i_we,
    input  logic                       i_re,
    input  logic                       i_comp_en,
    input  logic [ADDR_X+ADDR_Y-1:0]   fn_addr,
    input  logic [BG_DATA-1:0]         fn_wdata,
    input  logic                       fn_we,
    input  logic                       fn_re,
    input  logic [BG_DATA-1:0]         mem_rdata,
    output logic [ADDR_X+ADDR_Y-1:0]   mem_addr,
    output logic [BG_DATA-1:0]         mem_wdata,
    output logic                       mem_we,
    output logic                       mem_re,
    output logic                       o_fail_flag,
    input  logic                       shift_result,
    input  logic                       si,
    output logic                       so
);

    localparam int AW    = ADDR_X + ADDR_Y;
    localparam int RES_W = CNT_W + AW + BG_DATA + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TEST  = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t             state_q;

    logic               cmp_vld_q;
    logic [BG_DATA-1:0] exp_data_q;
    logic [AW-1:0]      cmp_addr_q;

    logic               fail_sticky_q, fail_sticky_d;
    logic [CNT_W-1:0]   fail_cnt_q,    fail_cnt_d;
    logic [AW-1:0]      first_addr_q,  first_addr_d;
    logic [BG_DATA-1:0] first_mask_q,  first_mask_d;
    logic               first_seen_q,  first_seen_d;

    logic [RES_W-1:0]   result_q;

    logic               start;
    logic [BG_DATA-1:0] mask;
    logic               mismatch;

    // Memory port mux: BIST owns the memory only while the test is running.
    always_comb begin
        if (state_q == TEST) begin
            mem_addr  = {i_addr_y, i_addr_x};
            mem_wdata = i_data;
            mem_we    = i_cs & i_we;
            mem_re    = i_cs & i_re;
        end else begin
            mem_addr  = fn_addr;
            mem_wdata = fn_wdata;
            mem_we    = fn_we;
            mem_re    = fn_re;
        end
    end

    // A new run starts on the same edge that enters TEST.
    assign start    = ((state_q == IDLE) || (state_q == HOLD)) && mbist_run;
    // cmp_vld_q can only be set by a TEST read, so it is live only in TEST or DRAIN.
    assign mask     = mem_rdata ^ exp_data_q;
    assign mismatch = cmp_vld_q && (mask != '0);

    // Accumulator next-state. The DRAIN result load uses these values, so a
    // compare that lands in DRAIN is still captured.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        fail_sticky_d = fail_sticky_q;
        fail_cnt_d    = fail_cnt_q;
        first_addr_d  = first_addr_q;
        first_mask_d  = first_mask_q;
        first_seen_d  = first_seen_q;
        if (start) begin
            fail_sticky_d = 1'b0;
            fail_cnt_d    = '0;
            first_addr_d  = '0;
            first_mask_d  = '0;
            first_seen_d  = 1'b0;
        end else if (mismatch) begin
            fail_sticky_d = 1'b1;
            if (fail_cnt_q != '1) begin
                fail_cnt_d = fail_cnt_q + CNT_W'(1);
            end
            if (!first_seen_q) begin
                first_addr_d = cmp_addr_q;
                first_mask_d = mask;
                first_seen_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q       <= IDLE;
            cmp_vld_q     <= 1'b0;
            exp_data_q    <= '0;
            cmp_addr_q    <= '0;
            fail_sticky_q <= 1'b0;
            fail_cnt_q    <= '0;
            first_addr_q  <= '0;
            first_mask_q  <= '0;
            first_seen_q  <= 1'b0;
            result_q      <= '0;
        end else begin
            case (state_q)
                IDLE:    if (mbist_run)  state_q <= TEST;
                TEST:    if (!mbist_run) state_q <= DRAIN;
                DRAIN:                   state_q <= HOLD;
                HOLD:    if (mbist_run)  state_q <= TEST;
                default:                 state_q <= IDLE;
            endcase

            if ((state_q == TEST) && mem_re) begin
                cmp_vld_q  <= i_comp_en;
                exp_data_q <= i_data;
                cmp_addr_q <= mem_addr;
            end else begin
                cmp_vld_q  <= 1'b0;
            end

            fail_sticky_q <= fail_sticky_d;
            fail_cnt_q    <= fail_cnt_d;
            first_addr_q  <= first_addr_d;
            first_mask_q  <= first_mask_d;
            first_seen_q  <= first_seen_d;

            // The parallel load in DRAIN wins over a shift request.
            if (state_q == DRAIN) begin
                result_q <= {fail_cnt_d, first_addr_d, first_mask_d, fail_sticky_d};
            end else if (shift_result) begin
                result_q <= {si, result_q[RES_W-1:1]};
            end
        end
    end

    assign o_fail_flag = fail_sticky_q;
    assign so          = result_q[0];

endmodule
